// File: rtl/scope_trigger_capture_if.sv
// Sample/trigger/readout bus between the ADC-side driver and scope_trigger_capture.
// master drives samples, trigger settings and read index; slave returns data and status.
interface scope_trigger_capture_if #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned DEPTH_LOG2 = 9
);
  logic [DATA_W-1:0]     sample_in;
  logic                  sample_valid;
  logic                  arm;
  logic [DATA_W-1:0]     trig_level;
  logic                  trig_slope;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  busy;
  logic                  capture_done;
  logic                  trig_forced;

  modport master (
    output sample_in, sample_valid, arm, trig_level, trig_slope, rd_addr,
    input  rd_data, busy, capture_done, trig_forced
  );

  modport slave (
    input  sample_in, sample_valid, arm, trig_level, trig_slope, rd_addr,
    output rd_data, busy, capture_done, trig_forced
  );
endinterface

// File: rtl/scope_trigger_capture.sv
// Edge-triggered pre/post capture of ADC samples into a ring buffer with logical-order readout.
// Optional auto-trigger timeout is built only when SCOPE_AUTO_TRIG_EN is defined.
module scope_trigger_capture #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned PRE_TRIG   = 128
`ifdef SCOPE_AUTO_TRIG_EN
  , parameter int unsigned AUTO_TMO = 4096
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  scope_trigger_capture_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PRE_W     = DEPTH_LOG2'(PRE_TRIG);
  localparam logic [DEPTH_LOG2-1:0] POST_INIT = DEPTH_LOG2'(DEPTH - PRE_TRIG - 1);
  localparam logic [DEPTH_LOG2-1:0] ONE       = DEPTH_LOG2'(1);

  typedef enum logic [2:0] {S_IDLE, S_PRETRIG, S_WAIT, S_POST, S_DONE} state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] cnt;
  logic [DEPTH_LOG2-1:0] start_ptr;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DATA_W-1:0]     prev;
  logic                  prev_valid;
  logic [DATA_W-1:0]     rd_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  wr_en;
  logic                  edge_hit;
  logic                  tmo_hit;
  logic [DATA_W-1:0]     mem [DEPTH];

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int unsigned TMO_W = $clog2(AUTO_TMO + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             forced_q;
  assign tmo_hit         = (tmo_cnt == TMO_W'(AUTO_TMO - 1));
  assign bus.trig_forced = forced_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.trig_forced = 1'b0;
`endif

  assign rd_idx           = start_ptr + bus.rd_addr;
  assign bus.rd_data      = rd_data_q;
  assign bus.busy         = busy_q;
  assign bus.capture_done = done_q;
  assign wr_en = bus.sample_valid &&
                 (state == S_PRETRIG || state == S_WAIT || state == S_POST);

  // Edge test of the incoming sample against the previously accepted one
  always_comb begin
    edge_hit = 1'b0;
    if (prev_valid) begin
      if (bus.trig_slope)
        edge_hit = (prev > bus.trig_level) && (bus.sample_in <= bus.trig_level);
      else
        edge_hit = (prev < bus.trig_level) && (bus.sample_in >= bus.trig_level);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.sample_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      cnt        <= '0;
      start_ptr  <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
      tmo_cnt    <= '0;
      forced_q   <= 1'b0;
`endif
    end else begin
      rd_data_q <= mem[rd_idx];
      if (wr_en) begin
        wr_ptr     <= wr_ptr + ONE;
        prev       <= bus.sample_in;
        prev_valid <= 1'b1;
      end
      case (state)
        S_IDLE, S_DONE: begin
          // A strobe coincident with arm is dropped: wr_en is low in these states
          if (bus.arm) begin
            state      <= S_PRETRIG;
            cnt        <= '0;
            wr_ptr     <= '0;
            prev_valid <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
            forced_q   <= 1'b0;
`endif
          end
        end
        S_PRETRIG: begin
          if (bus.sample_valid) begin
            cnt <= cnt + ONE;
            if (cnt + ONE == PRE_W) begin
              state <= S_WAIT;
`ifdef SCOPE_AUTO_TRIG_EN
              tmo_cnt <= '0;
`endif
            end
          end
        end
        S_WAIT: begin
          if (bus.sample_valid) begin
            if (edge_hit || tmo_hit) begin
              start_ptr <= wr_ptr - PRE_W;
              cnt       <= POST_INIT;
              state     <= S_POST;
`ifdef SCOPE_AUTO_TRIG_EN
              forced_q  <= !edge_hit;
`endif
            end
`ifdef SCOPE_AUTO_TRIG_EN
            else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
`endif
          end
        end
        S_POST: begin
          if (bus.sample_valid) begin
            cnt <= cnt - ONE;
            if (cnt == ONE) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture: a sample-history model predicts status every cycle
// and the expected frame contents; literal values pin the model on the documented scenarios.
module tb_scope_trigger_capture;
  localparam int DATA_W     = 12;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int PRE_TRIG   = 4;
  localparam int GAP        = 17;
`ifdef SCOPE_AUTO_TRIG_EN
  localparam int AUTO_TMO   = 8;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scope_trigger_capture_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  scope_trigger_capture #(
    .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .PRE_TRIG(PRE_TRIG)
`ifdef SCOPE_AUTO_TRIG_EN
    , .AUTO_TMO(AUTO_TMO)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Model: every sample accepted since arm, and the index of the trigger sample within it
  int hist[$];
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_forced = 1'b0;
  int m_trig   = -1;
  int m_wait   = 0;
  int m_level  = 0;
  bit m_slope  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit edge_ok(input int p, input int c);
    if (m_slope) return (p > m_level) && (c <= m_level);
    return (p < m_level) && (c >= m_level);
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_done = 1'b0; m_forced = 1'b0; m_trig = -1; m_wait = 0;
  endtask

  task automatic model_update(input bit a, input bit v, input int s);
    int i;
    if (!m_active || m_done) begin
      if (a) begin
        m_active = 1'b1; m_done = 1'b0; m_forced = 1'b0; m_trig = -1; m_wait = 0;
        hist.delete();
      end
    end else if (v) begin
      hist.push_back(s);
      i = hist.size() - 1;
      if (m_trig < 0) begin
        if (i >= PRE_TRIG) begin
          if (edge_ok(hist[i-1], hist[i])) m_trig = i;
          else begin
`ifdef SCOPE_AUTO_TRIG_EN
            m_wait++;
            if (m_wait == AUTO_TMO) begin m_trig = i; m_forced = 1'b1; end
`endif
          end
        end
      end else if (hist.size() == m_trig + DEPTH - PRE_TRIG) begin
        m_done = 1'b1;
      end
    end
  endtask

  // Status outputs against the model on every cycle out of reset
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("busy", int'(bus.busy), int'(m_active && !m_done));
      chk("capture_done", int'(bus.capture_done), int'(m_active && m_done));
      chk("trig_forced", int'(bus.trig_forced), int'(m_forced));
    end
  end

  task automatic set_trig(input int lvl, input bit slope);
    @(negedge clk);
    bus.trig_level = DATA_W'(lvl);
    bus.trig_slope = slope;
    m_level = lvl;
    m_slope = slope;
  endtask

  task automatic strobe(input int s, input bit a);
    @(negedge clk);
    bus.arm = a; bus.sample_valid = 1'b1; bus.sample_in = DATA_W'(s);
    @(posedge clk);
    model_update(a, 1'b1, s);
    @(negedge clk);
    bus.arm = 1'b0; bus.sample_valid = 1'b0;
    repeat (GAP - 2) @(posedge clk);
  endtask

  task automatic pulse_arm();
    @(negedge clk);
    bus.arm = 1'b1;
    @(posedge clk);
    model_update(1'b1, 1'b0, 0);
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  task automatic read_at(input string name, input int idx, input int exp);
    @(negedge clk);
    bus.rd_addr = DEPTH_LOG2'(idx);
    @(posedge clk);
    #1 chk(name, int'(bus.rd_data), exp);
  endtask

  task automatic read_frame(input string tag);
    chk({tag, "_done"}, int'(bus.capture_done), 1);
    if (!m_done) return;
    for (int a = 0; a < DEPTH; a++)
      read_at($sformatf("%s_rd%0d", tag, a), a, hist[m_trig - PRE_TRIG + a]);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.capture_done), 0);
    chk({tag, "_rd_data"}, int'(bus.rd_data), 0);
    chk({tag, "_forced"}, int'(bus.trig_forced), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_in = '0; bus.sample_valid = 1'b0; bus.arm = 1'b0;
    bus.trig_level = '0; bus.trig_slope = 1'b0; bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.capture_done), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    chk("rst_forced", int'(bus.trig_forced), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Rising ramp: trigger on 60, frame 20..170; a strobe in DONE must not write
    set_trig(55, 1'b0);
    pulse_arm();
    for (int k = 0; k < 18; k++) strobe(10 * k, 1'b0);
    chk("t1_done_lit", int'(bus.capture_done), 1);
    strobe(999, 1'b0);
    read_at("t1_rd0_lit", 0, 20);
    read_at("t1_rd4_lit", 4, 60);
    read_at("t1_rd15_lit", 15, 170);
    read_frame("t1");

    // Level already crossed in PRETRIG: never triggers
    set_trig(55, 1'b0);
    pulse_arm();
    for (int k = 0; k < 20; k++) strobe(50 + 10 * k, 1'b0);
    chk("t2_busy_lit", int'(bus.busy), 1);
    async_reset("t2_rst");

    // Falling ramp from 300: trigger on 250, oldest sample 290
    set_trig(255, 1'b1);
    pulse_arm();
    for (int k = 0; k < 17; k++) strobe(300 - 10 * k, 1'b0);
    read_at("t3_rd0_lit", 0, 290);
    read_at("t3_rd4_lit", 4, 250);
    read_frame("t3");

    // Falling trigger after the write pointer wrapped: start pointer crosses 0
    pulse_arm();
    for (int k = 0; k < 18; k++) strobe(300, 1'b0);
    strobe(250, 1'b0);
    for (int k = 0; k < 11; k++) strobe(200, 1'b0);
    read_at("t3w_rd0_lit", 0, 300);
    read_at("t3w_rd4_lit", 4, 250);
    read_at("t3w_rd5_lit", 5, 200);
    read_frame("t3w");

    // Reset mid-POSTTRIG, then a fresh capture
    set_trig(55, 1'b0);
    pulse_arm();
    for (int k = 0; k < 10; k++) strobe(10 * k, 1'b0);
    async_reset("t4_rst");
    pulse_arm();
    for (int k = 0; k < 17; k++) strobe(5 + 10 * k, 1'b0);
    read_at("t4_rd0_lit", 0, 15);
    read_at("t4_rd4_lit", 4, 55);
    read_frame("t4");

    // Arm coincident with a strobe in DONE drops it; arm while busy is ignored
    strobe(777, 1'b1);
    strobe(0, 1'b0);
    strobe(10, 1'b0);
    pulse_arm();
    strobe(20, 1'b1);
    for (int k = 3; k < 18; k++) strobe(10 * k, 1'b0);
    read_at("t5_rd0_lit", 0, 20);
    read_at("t5_rd4_lit", 4, 60);
    read_frame("t5");

    // Constant input below level: only the auto-trigger can close the frame
    set_trig(500, 1'b0);
    pulse_arm();
    for (int k = 0; k < 25; k++) strobe(100, 1'b0);
`ifdef SCOPE_AUTO_TRIG_EN
    chk("t6_done_lit", int'(bus.capture_done), 1);
    chk("t6_forced_lit", int'(bus.trig_forced), 1);
    read_frame("t6");
`else
    chk("t6_busy_lit", int'(bus.busy), 1);
    chk("t6_done_lit", int'(bus.capture_done), 0);
    chk("t6_forced_lit", int'(bus.trig_forced), 0);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
